// File: rtl/uart_sys_ctrl.sv
// uart_sys_ctrl: command controller between the UART RX/TX pair and the register file.
//
// It parses byte frames from the UART receiver and acts on each one:
//   0xAA addr data : register write
//   0xBB addr      : register read, with the read byte returned on the UART TX
//   0xCC cfg       : UART config update (PAR_EN=cfg[0], PAR_TYP=cfg[1], PRESCALE=cfg[7:2])
// The address is taken from byte[3:0]; bits [7:4] are ignored.
// An unknown opcode, a byte arriving while a command is executing, or an inter-byte timeout
// each produce a one-cycle ERR pulse.
//
// Ports
//   CLK, RST                : clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD      : received byte and its one-cycle strobe
//   TX_BUSY                 : UART TX busy flag
//   TX_P_DATA/TX_D_VLD      : byte to transmit and its one-cycle request
//   RF_ADDR/RF_WR_DATA      : register file address and write data
//   RF_WR_EN/RF_RD_EN       : one-cycle write and read strobes
//   RF_RD_DATA/RF_RD_VLD    : read data and its strobe
//   PAR_EN/PAR_TYP/PRESCALE : UART configuration
//   ERR                     : one-cycle protocol error pulse
module uart_sys_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_P_DATA,
  input  logic       RX_D_VLD,
  input  logic       TX_BUSY,
  output logic [7:0] TX_P_DATA,
  output logic       TX_D_VLD,
  output logic [3:0] RF_ADDR,
  output logic [7:0] RF_WR_DATA,
  output logic       RF_WR_EN,
  output logic       RF_RD_EN,
  input  logic [7:0] RF_RD_DATA,
  input  logic       RF_RD_VLD,
  output logic       PAR_EN,
  output logic       PAR_TYP,
  output logic [5:0] PRESCALE,
  output logic       ERR
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OpWrite = 8'hAA;
  localparam logic [7:0] OpRead  = 8'hBB;
  localparam logic [7:0] OpCfg   = 8'hCC;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StWrAddr   = 4'd1;
  localparam logic [3:0] StWrData   = 4'd2;
  localparam logic [3:0] StRdAddr   = 4'd3;
  localparam logic [3:0] StRdWait   = 4'd4;
  localparam logic [3:0] StTxReq    = 4'd5;
  localparam logic [3:0] StTxAck    = 4'd6;
  localparam logic [3:0] StCfgData  = 4'd7;
  localparam logic [3:0] StCfgApply = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      addr_q, addr_d;
  logic [7:0]      cfg_q, cfg_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_vld_q, tx_vld_d;
  logic [3:0]      rf_addr_q, rf_addr_d;
  logic [7:0]      rf_wr_data_q, rf_wr_data_d;
  logic            rf_wr_en_q, rf_wr_en_d;
  logic            rf_rd_en_q, rf_rd_en_d;
  logic            par_en_q, par_en_d;
  logic            par_typ_q, par_typ_d;
  logic [5:0]      prescale_q, prescale_d;
  logic            err_q, err_d;
  logic            timed;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cfg_d        = cfg_q;
    tx_data_d    = tx_data_q;
    tx_vld_d     = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    prescale_d   = prescale_q;
    err_d        = 1'b0;

    // Frame-collecting states are the only ones guarded by the inter-byte timeout.
    timed = (state_q == StWrAddr) || (state_q == StWrData) ||
            (state_q == StRdAddr) || (state_q == StCfgData);
    cnt_d = '0;
    if (timed && !RX_D_VLD) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            OpWrite: state_d = StWrAddr;
            OpRead:  state_d = StRdAddr;
            OpCfg:   state_d = StCfgData;
            default: err_d = 1'b1;
          endcase
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[3:0];
          state_d = StWrData;
        end
      end
      StWrData: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = RX_P_DATA;
          state_d      = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = RX_P_DATA[3:0];
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        err_d = RX_D_VLD;
        // A strobe coinciding with our own read request cannot be its answer.
        if (RF_RD_VLD && !rf_rd_en_q) begin
          tx_data_d = RF_RD_DATA;
          state_d   = StTxReq;
        end
      end
      StTxReq: begin
        err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = StTxAck;
        end
      end
      StTxAck: begin
        err_d = RX_D_VLD;
        if (TX_BUSY) state_d = StIdle;
      end
      StCfgData: begin
        if (RX_D_VLD) begin
          cfg_d   = RX_P_DATA;
          state_d = StCfgApply;
        end
      end
      StCfgApply: begin
        err_d = RX_D_VLD;
        // Never retune the UART underneath an ongoing transmission.
        if (!TX_BUSY) begin
          par_en_d   = cfg_q[0];
          par_typ_d  = cfg_q[1];
          prescale_d = cfg_q[7:2];
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timed && !RX_D_VLD && (cnt_q == CntLast)) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= 4'h0;
      cfg_q        <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_vld_q     <= 1'b0;
      rf_addr_q    <= 4'h0;
      rf_wr_data_q <= 8'h00;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      par_en_q     <= 1'b1;
      par_typ_q    <= 1'b0;
      prescale_q   <= 6'd32;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      cfg_q        <= cfg_d;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      prescale_q   <= prescale_d;
      err_q        <= err_d;
    end
  end

  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign RF_ADDR    = rf_addr_q;
  assign RF_WR_DATA = rf_wr_data_q;
  assign RF_WR_EN   = rf_wr_en_q;
  assign RF_RD_EN   = rf_rd_en_q;
  assign PAR_EN     = par_en_q;
  assign PAR_TYP    = par_typ_q;
  assign PRESCALE   = prescale_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Self-checking bench for uart_sys_ctrl: directed frames from the test plan plus a randomized
// frame stream, checked against a frame-level reference model (expected write/read/transmit
// queues, a register mirror, an expected error count and expected config).
module tb_uart_sys_ctrl;

  localparam int unsigned TimeoutCyc = 1024;
  localparam logic [31:0] RstVec = {8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'd32,
                                    1'b0};

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       tx_busy_mdl;
  logic       tx_force;
  wire        tx_busy = tx_busy_mdl | tx_force;
  logic [7:0] rf_rd_data;
  logic       rf_rd_vld;
  wire  [7:0] tx_p_data;
  wire        tx_d_vld;
  wire  [3:0] rf_addr;
  wire  [7:0] rf_wr_data;
  wire        rf_wr_en;
  wire        rf_rd_en;
  wire        par_en;
  wire        par_typ;
  wire  [5:0] prescale;
  wire        err;

  uart_sys_ctrl #(.TIMEOUT_CYC(TimeoutCyc)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (rx_data),
    .RX_D_VLD   (rx_vld),
    .TX_BUSY    (tx_busy),
    .TX_P_DATA  (tx_p_data),
    .TX_D_VLD   (tx_d_vld),
    .RF_ADDR    (rf_addr),
    .RF_WR_DATA (rf_wr_data),
    .RF_WR_EN   (rf_wr_en),
    .RF_RD_EN   (rf_rd_en),
    .RF_RD_DATA (rf_rd_data),
    .RF_RD_VLD  (rf_rd_vld),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .PRESCALE   (prescale),
    .ERR        (err)
  );

  always #5 CLK = ~CLK;

  wire [31:0] out_vec = {tx_p_data, tx_d_vld, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
                         par_en, par_typ, prescale, err};

  // Reference model state
  logic [7:0]  rf      [16];
  logic [7:0]  mem_exp [16];
  logic [11:0] exp_wr  [$];
  logic [3:0]  exp_rd  [$];
  logic [7:0]  exp_tx  [$];
  int          exp_err;
  int          err_cnt;
  logic        exp_pe;
  logic        exp_pt;
  logic [5:0]  exp_ps;
  int          n_vec;
  int          n_bad;
  int          tx_cnt;
  int          rd_delay_fix;
  logic        busy_edge;
  logic        rst_edge;
  logic [7:0]  cfg_prev;
  logic        tx_vld_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Values the DUT saw at the most recent rising edge.
  always @(posedge CLK) begin
    busy_edge <= tx_busy;
    rst_edge  <= RST;
  end

  // Monitor, register-file storage and UART TX busy model.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (rf_wr_en) begin
          check("wr_expected", 32'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0) check("wr_addr_data", {rf_addr, rf_wr_data}, exp_wr.pop_front());
          rf[rf_addr] = rf_wr_data;
        end
        if (rf_rd_en) begin
          check("rd_expected", 32'(exp_rd.size() != 0), 1);
          if (exp_rd.size() != 0) check("rd_addr", rf_addr, exp_rd.pop_front());
        end
        if (tx_d_vld) begin
          check("tx_expected", 32'(exp_tx.size() != 0), 1);
          if (exp_tx.size() != 0) check("tx_data", tx_p_data, exp_tx.pop_front());
        end
        if (tx_vld_prev) check("tx_vld_one_cycle", tx_d_vld, 0);
        if (err) err_cnt++;
        if (rst_edge === 1'b0 && {par_en, par_typ, prescale} != cfg_prev)
          check("cfg_change_while_busy", busy_edge, 0);
      end
      cfg_prev    = {par_en, par_typ, prescale};
      tx_vld_prev = tx_d_vld;
      if (tx_cnt > 0) tx_cnt--;
      if (tx_d_vld) tx_cnt = int'($urandom_range(2, 8));
      tx_busy_mdl = (tx_cnt != 0);
    end
  end

  // Register file read responder; sometimes also drives a junk strobe alongside RF_RD_EN.
  initial begin
    logic [3:0] a;
    int         d;
    forever begin
      @(negedge CLK);
      if (rf_rd_en && !RST) begin
        a = rf_addr;
        if ($urandom_range(0, 2) == 0) begin
          rf_rd_vld  = 1'b1;
          rf_rd_data = 8'hEE;
        end
        d = (rd_delay_fix > 0) ? rd_delay_fix : int'($urandom_range(1, 4));
        @(posedge CLK); #1;
        rf_rd_vld = 1'b0;
        for (int i = 1; i < d; i++) begin
          @(posedge CLK); #1;
        end
        rf_rd_vld  = 1'b1;
        rf_rd_data = rf[a];
        @(posedge CLK); #1;
        rf_rd_vld  = 1'b0;
        rf_rd_data = 8'($urandom);
      end
    end
  end

  task automatic cycle();
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) cycle();
    rx_data = b;
    rx_vld  = 1'b1;
    cycle();
    rx_vld  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic settle(input bit wait_busy);
    int n = 0;
    while ((exp_tx.size() != 0 || (wait_busy && tx_busy)) && n < 500) begin
      cycle();
      n++;
    end
    check("settle_in_bound", 32'(n < 500), 1);
    repeat (2) cycle();
    check("err_count", err_cnt, exp_err);
    check("cfg", {par_en, par_typ, prescale}, {exp_pe, exp_pt, exp_ps});
  endtask

  task automatic rand_frame();
    int         kind = int'($urandom_range(0, 19));
    logic [3:0] a    = 4'($urandom);
    logic [3:0] hi   = 4'($urandom);
    logic [7:0] b    = 8'($urandom);
    bit         wb   = 1'($urandom);
    if (kind < 8) begin
      exp_wr.push_back({a, b});
      mem_exp[a] = b;
      send_byte(8'hAA, $urandom_range(0, 5));
      send_byte({hi, a}, $urandom_range(0, 5));
      send_byte(b, $urandom_range(0, 5));
    end else if (kind < 15) begin
      exp_rd.push_back(a);
      exp_tx.push_back(mem_exp[a]);
      send_byte(8'hBB, $urandom_range(0, 5));
      send_byte({hi, a}, $urandom_range(0, 5));
      if (kind == 14) begin
        exp_err++;
        send_byte(b, 0);
      end
    end else if (kind < 18) begin
      exp_pe = b[0];
      exp_pt = b[1];
      exp_ps = b[7:2];
      wb     = 1'b1;
      send_byte(8'hCC, $urandom_range(0, 5));
      send_byte(b, $urandom_range(0, 5));
    end else begin
      while (b == 8'hAA || b == 8'hBB || b == 8'hCC) b = 8'($urandom);
      exp_err++;
      send_byte(b, $urandom_range(0, 5));
    end
    settle(wb);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int err0;
    RST = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; tx_force = 1'b0; tx_busy_mdl = 1'b0;
    rf_rd_vld = 1'b0; rf_rd_data = 8'h00;
    n_vec = 0; n_bad = 0; exp_err = 0; err_cnt = 0; tx_cnt = 0; rd_delay_fix = 0;
    exp_pe = 1'b1; exp_pt = 1'b0; exp_ps = 6'd32;
    for (int i = 0; i < 16; i++) begin
      rf[i]      = 8'($urandom);
      mem_exp[i] = rf[i];
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", out_vec, RstVec);
    cycle();
    RST = 1'b0;
    cycle();

    // Write 0x5C to address 3.
    exp_wr.push_back({4'h3, 8'h5C});
    mem_exp[3] = 8'h5C;
    send_byte(8'hAA, 0);
    send_byte(8'h03, 2);
    send_byte(8'h5C, 1);
    @(negedge CLK);
    check("wr_strobe_timing", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h3, 8'h5C});
    @(negedge CLK);
    check("wr_strobe_one_cycle", rf_wr_en, 0);
    cycle();
    settle(1'b0);

    // Read address 7, data 0xA5 after 3 cycles, TX idle.
    rf[7] = 8'hA5; mem_exp[7] = 8'hA5; rd_delay_fix = 3;
    exp_rd.push_back(4'h7);
    exp_tx.push_back(8'hA5);
    send_byte(8'hBB, 0);
    send_byte(8'h07, 1);
    @(negedge CLK);
    check("rd_strobe_timing", {rf_rd_en, rf_addr}, {1'b1, 4'h7});
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!tx_d_vld && n < 50);
    check("rd_to_tx_latency", n, 5);
    rd_delay_fix = 0;
    cycle();
    settle(1'b1);

    // Config 0x41 under a 20-cycle busy window.
    tx_force = 1'b1;
    send_byte(8'hCC, 0);
    send_byte(8'h41, 0);
    repeat (20) cycle();
    @(negedge CLK);
    check("cfg_hold_busy", {par_en, par_typ, prescale}, {1'b1, 1'b0, 6'd32});
    cycle();
    tx_force = 1'b0;
    @(negedge CLK);
    check("cfg_hold_edge", {par_en, par_typ, prescale}, {1'b1, 1'b0, 6'd32});
    @(negedge CLK);
    check("cfg_applied", {par_en, par_typ, prescale}, {1'b1, 1'b0, 6'd16});
    exp_pe = 1'b1; exp_pt = 1'b0; exp_ps = 6'd16;
    cycle();
    settle(1'b1);

    // Inter-byte timeout after a write address, then a normal write.
    err0 = err_cnt;
    send_byte(8'hAA, 0);
    send_byte(8'h02, 1);
    repeat (1000) cycle();
    check("timeout_not_early", err_cnt - err0, 0);
    repeat (100) cycle();
    check("timeout_err", err_cnt - err0, 1);
    exp_err++;
    exp_wr.push_back({4'h2, 8'h11});
    mem_exp[2] = 8'h11;
    send_byte(8'hAA, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    settle(1'b0);

    // Unknown opcode, then a read with a stray byte during the read wait.
    exp_err += 2;
    exp_rd.push_back(4'h5);
    exp_tx.push_back(mem_exp[5]);
    send_byte(8'h37, 0);
    send_byte(8'hBB, 1);
    send_byte(8'h05, 0);
    send_byte(8'h99, 0);
    settle(1'b1);

    for (int f = 0; f < 80; f++) rand_frame();
    settle(1'b1);

    // Reset while in the write-data state, then a stray 0x11.
    send_byte(8'hAA, 0);
    send_byte(8'h05, 0);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    @(negedge CLK);
    check("reset_midframe_outputs", out_vec, RstVec);
    exp_pe = 1'b1; exp_pt = 1'b0; exp_ps = 6'd32;
    cycle();
    exp_err++;
    send_byte(8'h11, 0);
    settle(1'b1);

    check("pending_wr", exp_wr.size(), 0);
    check("pending_rd", exp_rd.size(), 0);
    check("pending_tx", exp_tx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_sys_ctrl.md
# uart_sys_ctrl

Command controller that sits between the UART receiver/transmitter pair and the system register file. It parses byte frames from the UART RX, performs register writes and reads, and returns read data through the UART TX with a busy-aware handshake. It also owns the UART configuration register (parity enable, parity type, RX prescale) and drives it into the UART. One clock domain; the UART TX and RX datapaths must already be synchronized to `CLK`.

## Interface
- `TIMEOUT_CYC`, 1024: idle cycles allowed between bytes of one frame before the frame is aborted.
- `CLK` in 1: system clock.
- `RST` in 1: synchronous, active-high reset.
- `RX_P_DATA` in 8: received byte, valid while `RX_D_VLD` is high.
- `RX_D_VLD` in 1: one-cycle strobe per received byte.
- `TX_BUSY` in 1: UART TX busy flag.
- `TX_P_DATA` out 8: byte to transmit.
- `TX_D_VLD` out 1: one-cycle transmit request.
- `RF_ADDR` out 4: register file address.
- `RF_WR_DATA` out 8: register file write data.
- `RF_WR_EN` out 1: one-cycle write strobe.
- `RF_RD_EN` out 1: one-cycle read strobe.
- `RF_RD_DATA` in 8: read data, valid with `RF_RD_VLD`.
- `RF_RD_VLD` in 1: read-data strobe, arriving 1 or more cycles after `RF_RD_EN`.
- `PAR_EN` out 1: UART parity enable.
- `PAR_TYP` out 1: UART parity type (0 = even, 1 = odd).
- `PRESCALE` out 6: UART RX oversampling prescale.
- `ERR` out 1: one-cycle pulse on a protocol error.

## Operation
- Frames: the first byte is the opcode; the address is `RX_P_DATA[3:0]`, and bits [7:4] are ignored.
  - `0xAA, addr, data`: register write.
  - `0xBB, addr`: register read; the read byte is returned on TX.
  - `0xCC, cfg`: config update. `PAR_EN`=cfg[0], `PAR_TYP`=cfg[1], `PRESCALE`=cfg[7:2].
- States and transitions:
  - IDLE: on an opcode byte, go to WR_ADDR, RD_ADDR or CFG_DATA.
  - WR_ADDR → WR_DATA: latch the address.
  - WR_DATA → IDLE: issue the write.
  - RD_ADDR → RD_WAIT: issue the read.
  - RD_WAIT → TX_REQ: on `RF_RD_VLD`, latch the data.
  - TX_REQ → TX_ACK: when `TX_BUSY`=0, pulse `TX_D_VLD`.
  - TX_ACK → IDLE: when `TX_BUSY`=1.
  - CFG_DATA → CFG_APPLY: latch the cfg byte.
  - CFG_APPLY → IDLE: when `TX_BUSY`=0, update the config outputs.
- Unknown opcode in IDLE: drop the byte, pulse `ERR`, stay in IDLE.
- Byte received in RD_WAIT, TX_REQ, TX_ACK or CFG_APPLY: drop it, pulse `ERR`, keep the current state.
- Inter-byte timeout:
  - In WR_ADDR, WR_DATA, RD_ADDR or CFG_DATA, a counter increments each cycle without `RX_D_VLD` and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYC`-1: go to IDLE, pulse `ERR`, issue no RF access.
  - RD_WAIT, TX_REQ and TX_ACK wait indefinitely; only reset exits them.
- Config writes with `PRESCALE` not in {8, 16, 32} are still applied; range checking is not this block's job.

## Timing
- Reset values:
  - State IDLE.
  - `TX_P_DATA`=0, `TX_D_VLD`=0.
  - `RF_ADDR`=0, `RF_WR_DATA`=0, `RF_WR_EN`=0, `RF_RD_EN`=0.
  - `PAR_EN`=1, `PAR_TYP`=0, `PRESCALE`=32.
  - `ERR`=0, timeout counter 0.
- All outputs are registered.
- Write: `RF_WR_EN`, `RF_ADDR` and `RF_WR_DATA` are valid in the cycle after the data byte's `RX_D_VLD` cycle, for one cycle.
- Read: `RF_RD_EN` pulses in the cycle after the address byte's `RX_D_VLD` cycle. `RF_ADDR` holds its value until the next access.
- `RF_RD_VLD` in the same cycle as `RF_RD_EN` is ignored. Data is captured only while in RD_WAIT.
- TX: `TX_D_VLD` rises in the cycle after TX_REQ sees `TX_BUSY`=0, lasts exactly one cycle, and `TX_P_DATA` is stable in that cycle and afterwards. If `TX_BUSY` is already 0, the minimum delay from `RF_RD_VLD` to `TX_D_VLD` is 2 cycles.
- Config: outputs change together, in the cycle after CFG_APPLY sees `TX_BUSY`=0. They never change while `TX_BUSY`=1.
- `ERR` is asserted in the cycle after the offending byte, or the cycle after the timeout expires.
- Reset mid-frame: return to IDLE on the next edge and drop all pending strobes. Config returns to its reset values.

## Test plan
- Reset then `0xAA,0x03,0x5C` → `RF_WR_EN` pulses once with `RF_ADDR`=3, `RF_WR_DATA`=0x5C, one cycle after the third strobe. `ERR` stays 0.
- `0xBB,0x07`, RF returns 0xA5 after 3 cycles, `TX_BUSY`=0 → `RF_RD_EN` pulses with `RF_ADDR`=7. `TX_D_VLD` pulses with `TX_P_DATA`=0xA5. The FSM idles after `TX_BUSY` rises.
- `0xCC,0x41` while `TX_BUSY`=1 for 20 cycles → config holds `PAR_EN`=1, `PAR_TYP`=0, `PRESCALE`=32 until busy falls. Then it changes to `PAR_EN`=1, `PAR_TYP`=0, `PRESCALE`=16 in the next cycle.
- `0xAA,0x02`, then no byte for 1024 cycles → `ERR` pulses once and no `RF_WR_EN` is issued. A following `0xAA,0x02,0x11` writes normally.
- Opcode `0x37`, and an extra byte during RD_WAIT → `ERR` pulses once per bad byte. The read completes with the correct data.
- `RST` asserted in WR_DATA, then `0x11` received → no write occurs. All outputs are at their reset values one cycle after `RST`.
